// File: rtl/regfile_hilo.sv
// 32x32 GPR file plus HI/LO with EX/MEM/WB forwarding and load-use stall detect.
// Reads are combinational (zero latency); no backpressure, stallreq_load asks upstream to hold.
module regfile_hilo #(
  parameter int BYPASS_EN = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [37:0] wb_to_rf_bus,
  input  logic [65:0] wb_hilo_bus,
  input  logic [37:0] ex_fwd_bus,
  input  logic [37:0] mem_fwd_bus,
  input  logic [65:0] ex_hilo_bus,
  input  logic [65:0] mem_hilo_bus,
  input  logic        ex_is_load,
  input  logic        re1,
  input  logic        re2,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        stallreq_load
);

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } gpr_wr_t;

  typedef struct packed {
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_wr_t;

  gpr_wr_t  wb_wr, ex_wr, mem_wr;
  hilo_wr_t wb_hl, ex_hl, mem_hl;

  assign wb_wr  = wb_to_rf_bus;
  assign ex_wr  = ex_fwd_bus;
  assign mem_wr = mem_fwd_bus;
  assign wb_hl  = wb_hilo_bus;
  assign ex_hl  = ex_hilo_bus;
  assign mem_hl = mem_hilo_bus;

  logic [31:0] gpr [32];
  logic [31:0] hi_r;
  logic [31:0] lo_r;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < 32; i++) gpr[i] <= '0;
      hi_r <= '0;
      lo_r <= '0;
    end else begin
      if (wb_wr.we && wb_wr.waddr != 5'd0) gpr[wb_wr.waddr] <= wb_wr.wdata;
      if (wb_hl.hi_we) hi_r <= wb_hl.hi;
      if (wb_hl.lo_we) lo_r <= wb_hl.lo;
    end
  end

  // Youngest in-flight producer wins; $0 and disabled ports always read zero.
  function automatic logic [31:0] gpr_read(
    input logic        re,
    input logic [4:0]  ra,
    input logic [31:0] stored,
    input gpr_wr_t     ex,
    input gpr_wr_t     mem,
    input gpr_wr_t     wb
  );
    logic [31:0] val;
    val = stored;
    if (BYPASS_EN != 0) begin
      if (ex.we && ex.waddr == ra)        val = ex.wdata;
      else if (mem.we && mem.waddr == ra) val = mem.wdata;
      else if (wb.we && wb.waddr == ra)   val = wb.wdata;
    end
    if (!re || ra == 5'd0) val = '0;
    return val;
  endfunction

  function automatic logic [31:0] hilo_read(
    input logic [31:0] stored,
    input logic        ex_we,
    input logic [31:0] ex_v,
    input logic        mem_we,
    input logic [31:0] mem_v,
    input logic        wb_we,
    input logic [31:0] wb_v
  );
    logic [31:0] val;
    val = stored;
    if (BYPASS_EN != 0) begin
      if (ex_we)       val = ex_v;
      else if (mem_we) val = mem_v;
      else if (wb_we)  val = wb_v;
    end
    return val;
  endfunction

  assign rdata1 = gpr_read(re1, raddr1, gpr[raddr1], ex_wr, mem_wr, wb_wr);
  assign rdata2 = gpr_read(re2, raddr2, gpr[raddr2], ex_wr, mem_wr, wb_wr);
  assign hi_o   = hilo_read(hi_r, ex_hl.hi_we, ex_hl.hi, mem_hl.hi_we, mem_hl.hi,
                            wb_hl.hi_we, wb_hl.hi);
  assign lo_o   = hilo_read(lo_r, ex_hl.lo_we, ex_hl.lo, mem_hl.lo_we, mem_hl.lo,
                            wb_hl.lo_we, wb_hl.lo);

  logic ex_load_live;
  assign ex_load_live  = ex_is_load && ex_wr.we && ex_wr.waddr != 5'd0;
  assign stallreq_load = ex_load_live &&
                         ((re1 && raddr1 == ex_wr.waddr) || (re2 && raddr2 == ex_wr.waddr));

endmodule

// File: tb/tb_regfile_hilo.sv
// Randomized and directed checks of regfile_hilo against a priority-list reference model.
module tb_regfile_hilo;

  logic        clk = 1'b0;
  logic        resetn;
  logic [37:0] wb_to_rf_bus, ex_fwd_bus, mem_fwd_bus;
  logic [65:0] wb_hilo_bus, ex_hilo_bus, mem_hilo_bus;
  logic        ex_is_load, re1, re2;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2, hi_o, lo_o;
  logic        stallreq_load;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] m_gpr [32];
  logic [31:0] m_hi, m_lo;

  regfile_hilo #(.BYPASS_EN(1)) dut (
    .clk(clk), .resetn(resetn),
    .wb_to_rf_bus(wb_to_rf_bus), .wb_hilo_bus(wb_hilo_bus),
    .ex_fwd_bus(ex_fwd_bus), .mem_fwd_bus(mem_fwd_bus),
    .ex_hilo_bus(ex_hilo_bus), .mem_hilo_bus(mem_hilo_bus),
    .ex_is_load(ex_is_load), .re1(re1), .re2(re2),
    .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rdata1), .rdata2(rdata2), .hi_o(hi_o), .lo_o(lo_o),
    .stallreq_load(stallreq_load)
  );

  always #5 clk = ~clk;

  // Reference: scan producers youngest-first, fall back to the stored value.
  function automatic logic [31:0] exp_rd(input logic re, input logic [4:0] ra);
    logic [37:0] prod [3];
    prod[0] = ex_fwd_bus; prod[1] = mem_fwd_bus; prod[2] = wb_to_rf_bus;
    if (!re || ra == 5'd0) return 32'h0;
    for (int k = 0; k < 3; k++)
      if (prod[k][37] && prod[k][36:32] == ra) return prod[k][31:0];
    return m_gpr[ra];
  endfunction

  function automatic logic [31:0] exp_hl(input bit is_hi);
    logic [65:0] prod [3];
    prod[0] = ex_hilo_bus; prod[1] = mem_hilo_bus; prod[2] = wb_hilo_bus;
    for (int k = 0; k < 3; k++) begin
      if (is_hi && prod[k][65])  return prod[k][63:32];
      if (!is_hi && prod[k][64]) return prod[k][31:0];
    end
    return is_hi ? m_hi : m_lo;
  endfunction

  function automatic bit port_stalls(input logic re, input logic [4:0] ra);
    return ex_is_load && ex_fwd_bus[37] && ex_fwd_bus[36:32] != 5'd0 &&
           re && ra == ex_fwd_bus[36:32];
  endfunction

  task automatic idle();
    wb_to_rf_bus = '0; ex_fwd_bus = '0; mem_fwd_bus = '0;
    wb_hilo_bus = '0; ex_hilo_bus = '0; mem_hilo_bus = '0;
    ex_is_load = 1'b0; re1 = 1'b0; re2 = 1'b0; raddr1 = '0; raddr2 = '0;
  endtask

  // Apply the edge to the model with the inputs as they stand, then cross the edge.
  task automatic tick();
    if (!resetn) begin
      for (int i = 0; i < 32; i++) m_gpr[i] = 32'h0;
      m_hi = 32'h0; m_lo = 32'h0;
    end else begin
      if (wb_to_rf_bus[37] && wb_to_rf_bus[36:32] != 5'd0)
        m_gpr[wb_to_rf_bus[36:32]] = wb_to_rf_bus[31:0];
      if (wb_hilo_bus[65]) m_hi = wb_hilo_bus[63:32];
      if (wb_hilo_bus[64]) m_lo = wb_hilo_bus[31:0];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    resetn = 1'b0;
    wb_to_rf_bus = {1'b1, 5'd3, 32'h0000_0055};
    wb_hilo_bus  = {2'b11, 32'h0000_0066, 32'h0000_0077};
    ex_fwd_bus   = {1'b1, 5'd4, 32'hDEAD_BEEF};
    re1 = 1'b1; raddr1 = 5'd4;
    #1;
    n_cmp++;
    if (rdata1 !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL reset_fwd rdata1=%h want %h", rdata1, 32'hDEAD_BEEF);
    end
    tick();
    idle();
    resetn = 1'b1;
    for (int r = 1; r < 32; r++) begin
      re1 = 1'b1; re2 = 1'b1; raddr1 = 5'(r); raddr2 = 5'(r);
      #1;
      n_cmp++;
      if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
        n_fail++; $display("FAIL reset_gpr r%0d rdata1=%h rdata2=%h want 0", r, rdata1, rdata2);
      end
    end
    n_cmp++;
    if (hi_o !== 32'h0 || lo_o !== 32'h0 || stallreq_load !== 1'b0) begin
      n_fail++; $display("FAIL reset_hilo hi=%h lo=%h stall=%b want 0", hi_o, lo_o, stallreq_load);
    end
    idle();
  endtask

  task automatic test_wb_write();
    idle();
    wb_to_rf_bus = {1'b1, 5'd5, 32'h1234_5678};
    re1 = 1'b1; raddr1 = 5'd5;
    #1;
    n_cmp++;
    if (rdata1 !== 32'h1234_5678) begin
      n_fail++; $display("FAIL wb_same_cycle rdata1=%h want 12345678", rdata1);
    end
    tick();
    wb_to_rf_bus = '0;
    #1;
    n_cmp++;
    if (rdata1 !== 32'h1234_5678) begin
      n_fail++; $display("FAIL wb_next_cycle rdata1=%h want 12345678", rdata1);
    end
    idle();
  endtask

  task automatic test_r0();
    idle();
    wb_to_rf_bus = {1'b1, 5'd0, 32'hFFFF_FFFF};
    ex_fwd_bus   = {1'b1, 5'd0, 32'h0000_0ABC};
    re1 = 1'b1; re2 = 1'b1;
    #1;
    n_cmp++;
    if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
      n_fail++; $display("FAIL r0_fwd rdata1=%h rdata2=%h want 0", rdata1, rdata2);
    end
    tick();
    wb_to_rf_bus = '0; ex_fwd_bus = '0;
    #1;
    n_cmp++;
    if (rdata1 !== 32'h0) begin
      n_fail++; $display("FAIL r0_stored rdata1=%h want 0", rdata1);
    end
    idle();
  endtask

  task automatic test_priority();
    idle();
    ex_fwd_bus   = {1'b1, 5'd7, 32'hA};
    mem_fwd_bus  = {1'b1, 5'd7, 32'hB};
    wb_to_rf_bus = {1'b1, 5'd7, 32'hC};
    re2 = 1'b1; raddr2 = 5'd7;
    #1;
    n_cmp++;
    if (rdata2 !== 32'hA) begin n_fail++; $display("FAIL prio_ex rdata2=%h want a", rdata2); end
    ex_fwd_bus = '0;
    #1;
    n_cmp++;
    if (rdata2 !== 32'hB) begin n_fail++; $display("FAIL prio_mem rdata2=%h want b", rdata2); end
    mem_fwd_bus = '0;
    #1;
    n_cmp++;
    if (rdata2 !== 32'hC) begin n_fail++; $display("FAIL prio_wb rdata2=%h want c", rdata2); end
    tick();
    wb_to_rf_bus = '0;
    #1;
    n_cmp++;
    if (rdata2 !== 32'hC) begin n_fail++; $display("FAIL prio_array rdata2=%h want c", rdata2); end
    idle();
  endtask

  task automatic test_stall();
    idle();
    ex_is_load = 1'b1;
    ex_fwd_bus = {1'b1, 5'd9, 32'h0BAD_0BAD};
    re2 = 1'b1; raddr2 = 5'd9;
    #1;
    n_cmp++;
    if (stallreq_load !== 1'b1) begin n_fail++; $display("FAIL stall_hit2 stall=%b want 1", stallreq_load); end
    re2 = 1'b0;
    #1;
    n_cmp++;
    if (stallreq_load !== 1'b0) begin n_fail++; $display("FAIL stall_re0 stall=%b want 0", stallreq_load); end
    re1 = 1'b1; raddr1 = 5'd9;
    #1;
    n_cmp++;
    if (stallreq_load !== 1'b1) begin n_fail++; $display("FAIL stall_hit1 stall=%b want 1", stallreq_load); end
    ex_fwd_bus = {1'b1, 5'd0, 32'h0BAD_0BAD};
    re1 = 1'b1; raddr1 = 5'd0; re2 = 1'b1; raddr2 = 5'd0;
    #1;
    n_cmp++;
    if (stallreq_load !== 1'b0) begin n_fail++; $display("FAIL stall_r0 stall=%b want 0", stallreq_load); end
    idle();
  endtask

  task automatic test_hilo();
    logic [31:0] lo_before;
    idle();
    lo_before = m_lo;
    wb_hilo_bus = {1'b1, 1'b0, 32'h11, 32'h22};
    tick();
    wb_hilo_bus = '0;
    #1;
    n_cmp++;
    if (hi_o !== 32'h11 || lo_o !== lo_before) begin
      n_fail++; $display("FAIL hilo_wb hi=%h lo=%h want 11 %h", hi_o, lo_o, lo_before);
    end
    mem_hilo_bus = {1'b0, 1'b1, 32'h0, 32'h33};
    #1;
    n_cmp++;
    if (lo_o !== 32'h33 || hi_o !== 32'h11) begin
      n_fail++; $display("FAIL hilo_mem hi=%h lo=%h want 11 33", hi_o, lo_o);
    end
    tick();
    idle();
  endtask

  function automatic logic [37:0] rnd_wr();
    return {($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), 32'($urandom())};
  endfunction

  function automatic logic [65:0] rnd_hl();
    return {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
            32'($urandom()), 32'($urandom())};
  endfunction

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      resetn       = ($urandom_range(0, 39) != 0);
      wb_to_rf_bus = rnd_wr(); ex_fwd_bus = rnd_wr(); mem_fwd_bus = rnd_wr();
      wb_hilo_bus  = rnd_hl(); ex_hilo_bus = rnd_hl(); mem_hilo_bus = rnd_hl();
      ex_is_load   = ($urandom_range(0, 3) == 0);
      re1 = ($urandom_range(0, 3) != 0); re2 = ($urandom_range(0, 3) != 0);
      raddr1 = 5'($urandom_range(0, 7)); raddr2 = 5'($urandom_range(0, 7));
      #1;
      if (!port_stalls(re1, raddr1)) begin
        n_cmp++;
        if (rdata1 !== exp_rd(re1, raddr1)) begin
          n_fail++; $display("FAIL rnd_rdata1 cyc=%0d got %h want %h", c, rdata1, exp_rd(re1, raddr1));
        end
      end
      if (!port_stalls(re2, raddr2)) begin
        n_cmp++;
        if (rdata2 !== exp_rd(re2, raddr2)) begin
          n_fail++; $display("FAIL rnd_rdata2 cyc=%0d got %h want %h", c, rdata2, exp_rd(re2, raddr2));
        end
      end
      n_cmp++;
      if (hi_o !== exp_hl(1'b1) || lo_o !== exp_hl(1'b0)) begin
        n_fail++; $display("FAIL rnd_hilo cyc=%0d got %h/%h want %h/%h", c, hi_o, lo_o, exp_hl(1'b1), exp_hl(1'b0));
      end
      n_cmp++;
      if (stallreq_load !== (port_stalls(re1, raddr1) || port_stalls(re2, raddr2))) begin
        n_fail++; $display("FAIL rnd_stall cyc=%0d got %b", c, stallreq_load);
      end
      tick();
    end
    resetn = 1'b1;
    idle();
  endtask

  initial begin
    idle();
    resetn = 1'b0;
    for (int i = 0; i < 32; i++) m_gpr[i] = 32'h0;
    m_hi = 32'h0; m_lo = 32'h0;
    test_reset();
    test_wb_write();
    test_r0();
    test_priority();
    test_stall();
    test_hilo();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_hilo.md
REGFILE_HILO -- requirements
Module: regfile_hilo

Interface
REQ-001 SHALL have parameter BYPASS_EN, default 1; 1 enables EX/MEM/WB forwarding, 0 returns array contents only.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port resetn  input  1  reset; one clock; reset is synchronous and active-low.
REQ-004 SHALL have port wb_to_rf_bus  input  38  {we[37], waddr[36:32], wdata[31:0]} GPR write from writeback.
REQ-005 SHALL have port wb_hilo_bus  input  66  {hi_we[65], lo_we[64], hi[63:32], lo[31:0]} HI/LO write from writeback.
REQ-006 SHALL have ports ex_fwd_bus, mem_fwd_bus  input  38 each  same layout as wb_to_rf_bus, in-flight results.
REQ-007 SHALL have ports ex_hilo_bus, mem_hilo_bus  input  66 each  same layout as wb_hilo_bus.
REQ-008 SHALL have port ex_is_load  input  1  instruction in EX is a load; its wdata is not yet valid.
REQ-009 SHALL have ports re1, re2  input  1 each  read enables; raddr1, raddr2  input  5 each  read addresses.
REQ-010 SHALL have ports rdata1, rdata2  output  32 each  GPR read data.
REQ-011 SHALL have ports hi_o, lo_o  output  32 each  HI/LO read data.
REQ-012 SHALL have port stallreq_load  output  1  load-use stall request to the stall controller.

Function
REQ-013 SHALL hold 32x32-bit GPR array, 32-bit HI, 32-bit LO, all updated only on rising clk.
REQ-014 SHALL write GPR[waddr] <= wdata at clk edge when wb we=1 and waddr!=0; writes to $0 discarded.
REQ-015 SHALL update HI when hi_we=1 and LO when lo_we=1, independently, same edge.
REQ-016 SHALL compute rdata1/rdata2/hi_o/lo_o combinationally, zero-cycle latency.
REQ-017 SHALL return 0 on rdataN when reN=0 or raddrN=0, regardless of any forwarding bus.
REQ-018 SHALL, with BYPASS_EN=1, select GPR source by priority EX > MEM > WB > array, each bus matching only when we=1 and waddr==raddrN.
REQ-019 SHALL, with BYPASS_EN=1, select HI (and separately LO) by priority EX > MEM > WB > register using that half's we bit.
REQ-020 SHALL assert stallreq_load when ex_is_load=1, ex we=1, ex waddr!=0, and (re1 and raddr1==ex waddr) or (re2 and raddr2==ex waddr); else 0.
REQ-021 SHALL leave rdataN unspecified while stallreq_load=1 for that port; correct value after the stall bubble via MEM forwarding.
REQ-022 SHALL, when same-cycle WB write and read hit same address, return new wdata (write-through), array updated at edge.
REQ-023 SHALL ignore write buses with we=0 even if data/address nonzero.

Reset
REQ-024 SHALL clear all 32 GPRs, HI and LO to 0 on any clk edge with resetn=0.
REQ-025 SHALL drop WB writes presented in a reset cycle (reset wins over write).
REQ-026 SHALL yield rdata1=rdata2=hi_o=lo_o=0 and stallreq_load=0 after reset with all buses idle (we=0, ex_is_load=0).
REQ-027 SHALL keep combinational forwarding active during reset; only stored state is cleared.

Verification
REQ-028 SHALL cover: reset, then read r1..r31 with buses idle -> all rdata=0, hi_o=lo_o=0.
REQ-029 SHALL cover: WB write r5=0x1234_5678, next cycle re1=1 raddr1=5 -> rdata1=0x1234_5678; same-cycle read -> also 0x1234_5678.
REQ-030 SHALL cover: write r0=0xFFFF_FFFF, plus EX bus we=1 waddr=0 -> rdata of raddr 0 stays 0.
REQ-031 SHALL cover: EX r7=0xA, MEM r7=0xB, WB r7=0xC same cycle, raddr2=7 -> rdata2=0xA; drop EX -> 0xB; drop MEM -> 0xC.
REQ-032 SHALL cover: ex_is_load=1 ex waddr=9, re2=1 raddr2=9 -> stallreq_load=1; re2=0 -> 0; waddr=0 -> 0.
REQ-033 SHALL cover: wb_hilo hi_we=1 lo_we=0 hi=0x11 lo=0x22 -> next cycle hi_o=0x11, lo_o unchanged; MEM lo_we=1 lo=0x33 -> lo_o=0x33.
